slave_port: RTL and testbench
=============================

// Module: slave_port
// PURPOSE
//  Bus-side endpoint downstream of master_port on the bit-serial system bus. Deserialises a
//  16-bit address and, on writes, 8 data bits from wr_bus; decodes the device ID; acks; drives a
//  local memory interface; serialises read data back on rd_bus. Optional split on slow reads.
// PARAMETERS
//  SLAVE_ID         4'h0  device ID, compared with addr[15:12]
//  SPLIT_THRESHOLD  8     RWAIT cycles before split rises (used only with SLAVE_SPLIT_EN)
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rstn          in   1   synchronous active-low reset
//  mode          in   1   1=write, 0=read; sampled with address bit 0
//  wr_bus        in   1   serial master->slave line, LSB first
//  master_valid  in   1   wr_bus bit valid this cycle
//  master_ready  in   1   master can accept rd_bus bits
//  rd_bus        out  1   serial slave->master line, LSB first
//  slave_valid   out  1   rd_bus bit valid this cycle
//  slave_ready   out  1   slave accepting write-data bits
//  ack           out  1   one-cycle address-match acknowledge
//  split         out  1   level: read pending, bus released
//  s_addr        out  12  local address = addr[11:0]
//  s_wr_data     out  8   local write data
//  s_wr_en       out  1   one-cycle local write strobe
//  s_rd_en       out  1   one-cycle local read strobe
//  s_rd_data     in   8   local read data, valid with s_rd_valid
//  s_rd_valid    in   1   read data return, earliest cycle after s_rd_en
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output, state=IDLE, counters 0.
//  - Reset is synchronous and takes priority at any point, including mid-transfer; no local strobe
//    follows reset.
//  - IDLE: master_valid=1 -> capture wr_bus as addr[0], latch mode, bit_cnt=1 -> ADDR.
//  - ADDR: capture one bit per cycle. master_valid=0 before bit 15 -> IDLE with no ack (abort).
//    After bit 15 -> DECODE.
//  - DECODE: addr[15:12]==SLAVE_ID -> ack=1 for this cycle only, then WDATA (mode=1) or
//    RREQ (mode=0). Mismatch -> IDLE silently.
//  - WDATA: slave_ready=1. Capture 8 contiguous bits. master_valid=0 mid-byte -> IDLE, no write.
//    After bit 7 -> WRITE.
//  - WRITE: s_wr_en=1 for one cycle, with s_addr and s_wr_data stable -> IDLE.
//  - RREQ: s_rd_en=1 for one cycle -> RWAIT.
//  - RWAIT: latch s_rd_data on s_rd_valid; wait_cnt counts cycles and saturates. Data latched and
//    master_ready=1 -> RDATA. If s_rd_valid and master_ready=1 arrive in the same cycle, the
//    data is latched that cycle and RDATA is entered next.
//  - RDATA: slave_valid=1, rd_bus=data[bit_cnt] for 8 consecutive cycles (no stall) -> IDLE.
//  - bit_cnt is 4 bits and wraps to 0 on every state change; wr_bus is ignored outside
//    IDLE/ADDR/WDATA.
// CONFIGURATION
//  SLAVE_SPLIT_EN defined:
//    - in RWAIT, split rises when wait_cnt reaches SPLIT_THRESHOLD;
//    - split falls in the same cycle RDATA is entered;
//    - a read finishing before the threshold never raises split.
//  SLAVE_SPLIT_EN undefined: split tied 0, wait_cnt removed; RWAIT waits indefinitely.
// STRUCTURE
//  - sys_bus_pkg: ADDR_W=16, DATA_W=8, DEV_ID_W=4, LOCAL_ADDR_W=12,
//    typedef enum slave_state_t {IDLE, ADDR, DECODE, WDATA, WRITE, RREQ, RWAIT, RDATA}.
//  - One sub-module, serial_shift_reg: parameterised width, LSB-first shift-in/shift-out,
//    load and enable inputs. Two instances: address/data receive, read-data transmit.
// TESTING (SLAVE_ID=4'hA)
//  1. Write: mode=1, addr 16'hABCD + data 8'hD3 streamed contiguously -> ack one cycle;
//     s_wr_en one cycle with s_addr=12'hBCD, s_wr_data=8'hD3.
//  2. ID mismatch: addr 16'h5BCD, mode=1 -> ack, slave_ready, s_wr_en all remain 0.
//  3. Read: addr 16'hA012, mode=0, memory returns 8'h5A two cycles after s_rd_en,
//     master_ready=1 -> rd_bus 0,1,0,1,1,0,1,0 with slave_valid high for exactly 8 cycles.
//  4. Abort: master_valid drops after address bit 7 -> no ack, IDLE; next full write completes.
//  5. Split (macro on, threshold 8): read latency 20 -> split high from RWAIT cycle 8 until
//     RDATA entry. Macro off -> split stays 0 and the data still arrives.
//  6. Reset: rstn=0 during RDATA bit 3 -> next edge all outputs 0, state IDLE.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared widths and slave FSM state type for the bit-serial system bus.
package sys_bus_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 8;
  localparam int DEV_ID_W     = 4;
  localparam int LOCAL_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE, ADDR, DECODE, WDATA, WRITE, RREQ, RWAIT, RDATA
  } slave_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: serial bits enter at the MSB end, ser_out is bit 0.
// Parallel load takes priority over shifting.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift_en) begin
      data_q <= {ser_in, data_q[WIDTH-1:1]};
    end
  end

  assign ser_out = data_q[0];
  assign par_out = data_q;

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus slave: deserialises address/write data, decodes device ID, drives local memory
// strobes and returns read data serially. Split signalling on slow reads needs SLAVE_SPLIT_EN.
module slave_port
  import sys_bus_pkg::*;
#(
  parameter logic [DEV_ID_W-1:0] SLAVE_ID        = 4'h0,
  parameter int                  SPLIT_THRESHOLD = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mode,
  input  logic                    wr_bus,
  input  logic                    master_valid,
  input  logic                    master_ready,
  output logic                    rd_bus,
  output logic                    slave_valid,
  output logic                    slave_ready,
  output logic                    ack,
  output logic                    split,
  output logic [LOCAL_ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0]       s_wr_data,
  output logic                    s_wr_en,
  output logic                    s_rd_en,
  input  logic [DATA_W-1:0]       s_rd_data,
  input  logic                    s_rd_valid
);

  slave_state_t            state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    mode_q, mode_d;
  logic                    have_data_q, have_data_d;
  logic [LOCAL_ADDR_W-1:0] s_addr_q, s_addr_d;
  logic                    ack_q, ack_d;
  logic                    slave_ready_q, slave_valid_q, s_wr_en_q, s_rd_en_q;

  logic [ADDR_W-1:0]       rx_data;
  logic                    rx_shift, tx_load, tx_shift;
  logic                    rx_ser_unused;
  logic [DATA_W-1:0]       tx_par_unused;

  assign rx_shift = master_valid && (state_q inside {IDLE, ADDR, WDATA});
  assign tx_load  = (state_q == RWAIT) && s_rd_valid;
  assign tx_shift = (state_q == RDATA);

  // Address bits fill the receiver first; write data then pushes the top byte through.
  serial_shift_reg #(.WIDTH(ADDR_W)) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .load     (1'b0),
    .load_data('0),
    .shift_en (rx_shift),
    .ser_in   (wr_bus),
    .ser_out  (rx_ser_unused),
    .par_out  (rx_data)
  );

  serial_shift_reg #(.WIDTH(DATA_W)) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tx_load),
    .load_data(s_rd_data),
    .shift_en (tx_shift),
    .ser_in   (1'b0),
    .ser_out  (rd_bus),
    .par_out  (tx_par_unused)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    mode_d      = mode_q;
    have_data_d = have_data_q;
    s_addr_d    = s_addr_q;
    // Address bit 15 is still on wr_bus here, so ack lands exactly on the DECODE cycle.
    ack_d       = (state_q == ADDR) && master_valid && (bit_cnt_q == 4'd15) &&
                  ({wr_bus, rx_data[ADDR_W-1 -: DEV_ID_W-1]} == SLAVE_ID);
    unique case (state_q)
      IDLE: if (master_valid) begin
        mode_d  = mode;
        state_d = ADDR;
      end
      ADDR: begin
        if (!master_valid)            state_d = IDLE;
        else if (bit_cnt_q == 4'd15)  state_d = DECODE;
        else                          bit_cnt_d = bit_cnt_q + 4'd1;
      end
      DECODE: begin
        if (rx_data[ADDR_W-1 -: DEV_ID_W] == SLAVE_ID) begin
          s_addr_d = rx_data[LOCAL_ADDR_W-1:0];
          state_d  = mode_q ? WDATA : RREQ;
        end else begin
          state_d  = IDLE;
        end
      end
      WDATA: begin
        if (master_valid) begin
          if (bit_cnt_q == 4'd7) state_d = WRITE;
          else                   bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (bit_cnt_q != 4'd0) begin
          state_d = IDLE;
        end
      end
      WRITE: state_d = IDLE;
      RREQ: begin
        have_data_d = 1'b0;
        state_d     = RWAIT;
      end
      RWAIT: begin
        if (s_rd_valid) have_data_d = 1'b1;
        if ((have_data_q || s_rd_valid) && master_ready) state_d = RDATA;
      end
      RDATA: begin
        if (bit_cnt_q == 4'd7) state_d = IDLE;
        else                   bit_cnt_d = bit_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) bit_cnt_d = (state_d == ADDR) ? 4'd1 : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      mode_q        <= 1'b0;
      have_data_q   <= 1'b0;
      s_addr_q      <= '0;
      ack_q         <= 1'b0;
      slave_ready_q <= 1'b0;
      slave_valid_q <= 1'b0;
      s_wr_en_q     <= 1'b0;
      s_rd_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      mode_q        <= mode_d;
      have_data_q   <= have_data_d;
      s_addr_q      <= s_addr_d;
      ack_q         <= ack_d;
      slave_ready_q <= (state_d == WDATA);
      slave_valid_q <= (state_d == RDATA);
      s_wr_en_q     <= (state_d == WRITE);
      s_rd_en_q     <= (state_d == RREQ);
    end
  end

  assign ack         = ack_q;
  assign slave_ready = slave_ready_q;
  assign slave_valid = slave_valid_q;
  assign s_wr_en     = s_wr_en_q;
  assign s_rd_en     = s_rd_en_q;
  assign s_addr      = s_addr_q;
  assign s_wr_data   = rx_data[ADDR_W-1 -: DATA_W];

`ifdef SLAVE_SPLIT_EN
  localparam int                WAIT_W   = $clog2(SPLIT_THRESHOLD + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SPLIT_THRESHOLD);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              split_q;

  // wait_cnt holds the 1-based RWAIT cycle number, saturating at the threshold.
  always_comb begin
    wait_cnt_d = '0;
    if (state_d == RWAIT) begin
      if (state_q != RWAIT)            wait_cnt_d = WAIT_W'(1);
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      else                             wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
      split_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      split_q    <= (state_d == RWAIT) && (wait_cnt_d == WAIT_MAX);
    end
  end

  assign split = split_q;
`else
  localparam int split_threshold_unused = SPLIT_THRESHOLD;
  assign split = 1'b0;
`endif

endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: directed write/read/abort/split/reset cases plus random
// transactions checked against transaction-level expectations computed in the bench.
module tb_slave_port;
  import sys_bus_pkg::*;

  localparam logic [3:0] ID  = 4'hA;
  localparam int         THR = 8;

  logic        clk = 1'b0;
  logic        rstn, mode, wr_bus, master_valid, master_ready;
  logic        rd_bus, slave_valid, slave_ready, ack, split, s_wr_en, s_rd_en, s_rd_valid;
  logic [11:0] s_addr;
  logic [7:0]  s_wr_data, s_rd_data;

  slave_port #(.SLAVE_ID(ID), .SPLIT_THRESHOLD(THR)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
    .master_ready(master_ready), .rd_bus(rd_bus), .slave_valid(slave_valid),
    .slave_ready(slave_ready), .ack(ack), .split(split), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en), .s_rd_data(s_rd_data),
    .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: tallies what the DUT showed, one sample per cycle on the falling edge.
  int         cyc = 0;
  int         ack_n, ready_n, wr_n, rd_en_n, split_n, sv_n, rd_en_cyc, sv_first;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data, rd_bits;

  task automatic clear_mon();
    ack_n = 0; ready_n = 0; wr_n = 0; rd_en_n = 0; split_n = 0; sv_n = 0;
    rd_en_cyc = 0; sv_first = 0; wr_addr = '0; wr_data = '0; rd_bits = '0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ack)         ack_n++;
    if (slave_ready) ready_n++;
    if (split)       split_n++;
    if (s_wr_en) begin
      wr_n++;
      wr_addr = s_addr;
      wr_data = s_wr_data;
    end
    if (s_rd_en) begin
      rd_en_n++;
      rd_en_cyc = cyc;
    end
    if (slave_valid) begin
      if (sv_n == 0) sv_first = cyc;
      if (sv_n < 8) rd_bits[sv_n] = rd_bus;
      sv_n++;
    end
  end

  task automatic send_addr(input logic [15:0] a, input logic m, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      master_valid = 1'b1;
      wr_bus       = a[i];
      mode         = m;
    end
    @(negedge clk);
    master_valid = 1'b0;
    wr_bus       = 1'($urandom);
  endtask

  // nb < 8 drops master_valid mid-byte.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int nb,
                          input string tag);
    clear_mon();
    send_addr(a, 1'b1, 16);
    for (int n = 0; n < 6 && !slave_ready; n++) @(negedge clk);
    if (slave_ready) begin
      for (int j = 0; j < nb; j++) begin
        master_valid = 1'b1;
        wr_bus       = d[j];
        @(negedge clk);
      end
      master_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    #1;
    if (a[15:12] == ID) begin
      check({tag, "_ack"},   32'(ack_n), 32'd1);
      check({tag, "_ready"}, 32'(ready_n), (nb == 8) ? 32'd8 : 32'(nb + 1));
      check({tag, "_wr_en"}, 32'(wr_n), (nb == 8) ? 32'd1 : 32'd0);
      if (nb == 8) begin
        check({tag, "_s_addr"},    32'(wr_addr), 32'(a[11:0]));
        check({tag, "_s_wr_data"}, 32'(wr_data), 32'(d));
      end
    end else begin
      check({tag, "_ack"},   32'(ack_n), 32'd0);
      check({tag, "_ready"}, 32'(ready_n), 32'd0);
      check({tag, "_wr_en"}, 32'(wr_n), 32'd0);
    end
  endtask

  // lat: RWAIT cycle carrying s_rd_valid; mr: RWAIT cycle master_ready rises; rst_bit>=0 resets
  // the DUT during that RDATA bit.
  task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int lat, input int mr,
                         input int rst_bit, input string tag);
    int w, exp_split;
    bit seen;
    w = (lat > mr) ? lat : mr;
`ifdef SLAVE_SPLIT_EN
    exp_split = (w >= THR) ? (w - THR + 1) : 0;
`else
    exp_split = 0;
`endif
    clear_mon();
    send_addr(a, 1'b0, 16);
    for (int n = 0; n < 8 && !s_rd_en; n++) @(negedge clk);
    check({tag, "_rd_en_seen"}, 32'(s_rd_en), 32'd1);
    seen = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (slave_valid) begin
        seen = 1'b1;
        break;
      end
      s_rd_valid   = (c == lat);
      s_rd_data    = (c == lat) ? d : 8'($urandom);
      master_ready = (c >= mr);
    end
    s_rd_valid = 1'b0;
    check({tag, "_rdata_seen"},     32'(seen), 32'd1);
    check({tag, "_split_at_rdata"}, 32'(split), 32'd0);
    if (rst_bit >= 0) begin
      repeat (rst_bit) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "_outputs_zero"},
            32'({rd_bus, slave_valid, slave_ready, ack, split, s_wr_en, s_rd_en, s_addr,
                 s_wr_data}), 32'd0);
      check({tag, "_state_idle"}, 32'(dut.state_q), 32'(IDLE));
      check({tag, "_bits_before"}, 32'(sv_n), 32'(rst_bit + 1));
      check({tag, "_low_bits"}, 32'(rd_bits & 8'h0F), 32'(d & 8'h0F));
      rstn = 1'b1;
      clear_mon();
      repeat (10) @(negedge clk);
      #1;
      check({tag, "_no_strobe_after"}, 32'(wr_n + rd_en_n + sv_n), 32'd0);
    end else begin
      repeat (10) @(negedge clk);
      #1;
      check({tag, "_ack"},     32'(ack_n), 32'd1);
      check({tag, "_rd_en"},   32'(rd_en_n), 32'd1);
      check({tag, "_nbits"},   32'(sv_n), 32'd8);
      check({tag, "_data"},    32'(rd_bits), 32'(d));
      check({tag, "_latency"}, 32'(sv_first - rd_en_cyc), 32'(w + 1));
      check({tag, "_split_n"}, 32'(split_n), 32'(exp_split));
    end
    master_ready = 1'b0;
  endtask

  initial begin
    int          kind;
    logic [15:0] ra;
    logic [7:0]  rd;
    rstn = 1'b0; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
    s_rd_data = '0; s_rd_valid = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({rd_bus, slave_valid, slave_ready, ack, split, s_wr_en, s_rd_en, s_addr,
               s_wr_data}), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    rstn = 1'b1;

    do_write(16'hABCD, 8'hD3, 8, "write");
    do_write(16'h5BCD, 8'h77, 8, "id_mismatch");
    do_read(16'hA012, 8'h5A, 2, 1, -1, "read");

    clear_mon();
    send_addr(16'hABCD, 1'b1, 8);
    repeat (6) @(negedge clk);
    #1;
    check("abort_ack",   32'(ack_n), 32'd0);
    check("abort_ready", 32'(ready_n), 32'd0);
    check("abort_wr_en", 32'(wr_n), 32'd0);
    do_write(16'hA3C4, 8'h96, 8, "post_abort");
    do_write(16'hA155, 8'h3C, 4, "data_abort");

    do_read(16'hA777, 8'hC3, 20, 1, -1, "split_slow");
    do_read(16'hA456, 8'h81, 3, 9, -1, "ready_late");
    do_read(16'hA0F0, 8'hE7, 8, 8, -1, "split_edge");

    for (int k = 0; k < 12; k++) begin
      kind = int'($urandom_range(0, 2));
      ra   = 16'($urandom);
      rd   = 8'($urandom);
      case (kind)
        0: begin
          ra[15:12] = ID;
          do_write(ra, rd, 8, "rnd_write");
        end
        1: begin
          ra[15:12] = ID;
          do_read(ra, rd, int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), -1,
                  "rnd_read");
        end
        default: begin
          if (ra[15:12] == ID) ra[15:12] = 4'h3;
          do_write(ra, rd, 8, "rnd_mismatch");
        end
      endcase
    end

    do_read(16'hA012, 8'h5A, 2, 1, 3, "reset_mid_rdata");
    do_write(16'hAFED, 8'h42, 8, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
